asm_inserter: RTL and testbench



---
 rtl/asm_inserter.sv | 166 ++++++++++++++++
 tb/tb_asm_inserter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_inserter.sv
// asm_inserter: prepends a fixed attached sync marker (ASM) to every
// BLOCK_LEN-byte coded block arriving from the convolutional encoder.
// Framing is driven by an internal byte counter. The upstream sop/last
// flags are only checked, and any violation is reported on one-cycle
// error pulses. The data phase is a zero-latency combinational passthrough.
module asm_inserter #(
  parameter int          BLOCK_LEN = 512,
  parameter int          ASM_LEN   = 4,
  parameter logic [31:0] ASM_WORD  = 32'h1ACF_FC1D,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  // upstream (encoder) side
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  input  logic [7:0]       s_axis_data,
  input  logic             s_axis_last,
  input  logic             s_axis_sop,
  input  logic             s_axis_is_parity,
  // downstream (modulator) side
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic [7:0]       m_axis_data,
  output logic             m_axis_last,
  output logic             m_axis_sop,
  output logic             m_axis_is_parity,
  output logic             m_axis_is_asm,
  // status
  output logic             err_sop,
  output logic             err_len,
  output logic [CNT_W-1:0] frame_count
);

  localparam int BC_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(BLOCK_LEN - 1);
  localparam logic [1:0]      LAST_ASM = 2'(ASM_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ASM  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]       state_q,       state_d;
  logic [1:0]       asm_idx_q,     asm_idx_d;
  logic [BC_W-1:0]  byte_cnt_q,    byte_cnt_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             err_sop_q,     err_sop_d;
  logic             err_len_q,     err_len_d;

  // Byte idx of the marker, most significant byte first.
  function automatic logic [7:0] marker_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ASM_WORD[31:24];
      2'd1:    b = ASM_WORD[23:16];
      2'd2:    b = ASM_WORD[15:8];
      default: b = ASM_WORD[7:0];
    endcase
    return b;
  endfunction

  // Next-state logic, handshake steering and output multiplexing.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    state_d          = state_q;
    asm_idx_d        = asm_idx_q;
    byte_cnt_d       = byte_cnt_q;
    frame_count_d    = frame_count_q;
    err_sop_d        = 1'b0;
    err_len_d        = 1'b0;
    s_axis_ready     = 1'b0;
    m_axis_valid     = 1'b0;
    m_axis_data      = 8'h00;
    m_axis_last      = 1'b0;
    m_axis_sop       = 1'b0;
    m_axis_is_parity = 1'b0;
    m_axis_is_asm    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_axis_valid) begin
          if (s_axis_sop) begin
            // Hold the sop byte upstream. It becomes data byte 0 after the marker.
            state_d   = ST_ASM;
            asm_idx_d = 2'd0;
          end else begin
            // A stray byte outside a frame is accepted and discarded.
            s_axis_ready = 1'b1;
            err_sop_d    = 1'b1;
          end
        end
      end

      ST_ASM: begin
        m_axis_valid  = 1'b1;
        m_axis_data   = marker_byte(asm_idx_q);
        m_axis_is_asm = 1'b1;
        m_axis_sop    = (asm_idx_q == 2'd0);
        if (m_axis_ready) begin
          if (asm_idx_q == LAST_ASM) begin
            state_d    = ST_DATA;
            asm_idx_d  = 2'd0;
            byte_cnt_d = '0;
          end else begin
            asm_idx_d = asm_idx_q + 2'd1;
          end
        end
      end

      ST_DATA: begin
        m_axis_valid     = s_axis_valid;
        s_axis_ready     = m_axis_ready;
        m_axis_data      = s_axis_data;
        m_axis_is_parity = s_axis_is_parity;
        m_axis_last      = (byte_cnt_q == LAST_CNT) && s_axis_valid;
        if (s_axis_valid && m_axis_ready) begin
          err_sop_d = s_axis_sop && (byte_cnt_q != '0);
          err_len_d = s_axis_last != (byte_cnt_q == LAST_CNT);
          if (byte_cnt_q == LAST_CNT) begin
            state_d       = ST_IDLE;
            byte_cnt_d    = '0;
            frame_count_d = frame_count_q + 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The state register already sits in ST_IDLE during reset. Gating here
    // also keeps a stray byte from being accepted while reset is held.
    if (rst) begin
      s_axis_ready = 1'b0;
    end
  end

  // State, counters and error pulses.
  // NOTE: the reset is asynchronous and listed in the sensitivity list. All
  // state updates use non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      asm_idx_q     <= 2'd0;
      byte_cnt_q    <= '0;
      frame_count_q <= '0;
      err_sop_q     <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      asm_idx_q     <= asm_idx_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_count_q <= frame_count_d;
      err_sop_q     <= err_sop_d;
      err_len_q     <= err_len_d;
    end
  end

  assign err_sop     = err_sop_q;
  assign err_len     = err_len_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_asm_inserter.sv
// Self-checking bench for asm_inserter. A frame-level reference model turns
// each input byte list into the expected output byte stream and error counts.
// A monitor compares every output transfer against that stream.
module tb_asm_inserter;

  localparam int          BLOCK_LEN = 512;
  localparam int          ASM_LEN   = 4;
  localparam logic [31:0] ASM_WORD  = 32'h1ACF_FC1D;
  localparam int          CNT_W     = 2;

  logic             clk;
  logic             rst;
  logic             s_axis_valid, s_axis_ready;
  logic [7:0]       s_axis_data;
  logic             s_axis_last, s_axis_sop, s_axis_is_parity;
  logic             m_axis_valid, m_axis_ready;
  logic [7:0]       m_axis_data;
  logic             m_axis_last, m_axis_sop, m_axis_is_parity, m_axis_is_asm;
  logic             err_sop, err_len;
  logic [CNT_W-1:0] frame_count;

  asm_inserter #(
    .BLOCK_LEN(BLOCK_LEN), .ASM_LEN(ASM_LEN), .ASM_WORD(ASM_WORD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_sop(s_axis_sop), .s_axis_is_parity(s_axis_is_parity),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_sop(m_axis_sop), .m_axis_is_parity(m_axis_is_parity),
    .m_axis_is_asm(m_axis_is_asm),
    .err_sop(err_sop), .err_len(err_len), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       last;
    logic       par;
  } in_t;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       last;
    logic       par;
    logic       is_asm;
  } out_t;

  in_t  stim_q[$];
  out_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  int exp_err_sop = 0, exp_err_len = 0;
  int n_err_sop   = 0, n_err_len   = 0;
  logic [CNT_W-1:0] exp_fc = '0;
  bit   rand_ready = 0;
  bit   gap_mode   = 0;
  int   last_cyc   = -1;
  int   cyc        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model. Bytes outside a frame are dropped unless they carry sop.
  // A sop byte opens a frame: the marker comes first, then exactly BLOCK_LEN
  // bytes follow unchanged, whatever sop/last flags they carry.
  task automatic run_model();
    logic [31:0] w;
    bit in_frame;
    int cnt;
    out_t o;
    w = ASM_WORD;
    in_frame = 0;
    cnt = 0;
    foreach (stim_q[i]) begin
      if (!in_frame) begin
        if (stim_q[i].sop) begin
          for (int k = 0; k < ASM_LEN; k++) begin
            o.data = w[31-8*k -: 8];
            o.sop = (k == 0);
            o.last = 0;
            o.par = 0;
            o.is_asm = 1;
            exp_q.push_back(o);
          end
          in_frame = 1;
          cnt = 0;
        end else begin
          exp_err_sop++;
        end
      end
      if (in_frame) begin
        o.data = stim_q[i].data;
        o.sop = 0;
        o.last = (cnt == BLOCK_LEN - 1);
        o.par = stim_q[i].par;
        o.is_asm = 0;
        exp_q.push_back(o);
        if (stim_q[i].sop && cnt != 0) exp_err_sop++;
        if (stim_q[i].last != (cnt == BLOCK_LEN - 1)) exp_err_len++;
        cnt++;
        if (cnt == BLOCK_LEN) in_frame = 0;
      end
    end
  endtask

  // Appends one block. mode 0 gives data i mod 256, otherwise random data.
  // last is set at lp_a and lp_b (-1 = none). An extra sop goes at sop_err.
  // Parity is set on bytes par_lo..par_hi.
  task automatic add_block(input int mode, input int lp_a, input int lp_b,
                           input int sop_err, input int par_lo, input int par_hi);
    in_t it;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      it.data = (mode == 0) ? 8'(i) : 8'($urandom);
      it.sop  = (i == 0) || (i == sop_err);
      it.last = (i == lp_a) || (i == lp_b);
      it.par  = (i >= par_lo) && (i <= par_hi);
      stim_q.push_back(it);
    end
  endtask

  // Drives every byte of stim_q with AXI-stream semantics. Each byte is held
  // until it is accepted. gap_pct sets the chance of idle cycles before a byte.
  task automatic send(input int gap_pct);
    bit acc;
    int t;
    foreach (stim_q[i]) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      s_axis_valid     = 1'b1;
      s_axis_data      = stim_q[i].data;
      s_axis_sop       = stim_q[i].sop;
      s_axis_last      = stim_q[i].last;
      s_axis_is_parity = stim_q[i].par;
      t = 0;
      forever begin
        @(negedge clk);
        acc = s_axis_valid && s_axis_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        t++;
        if (t > 4000) begin
          check("drive_timeout", 32'(t), 32'd0);
          break;
        end
      end
    end
    s_axis_valid = 1'b0;
    s_axis_sop   = 1'b0;
    s_axis_last  = 1'b0;
    stim_q.delete();
  endtask

  // Waits for the expected stream to drain, then lets late pulses land.
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("err_sop_count", 32'(n_err_sop), 32'(exp_err_sop));
    check("err_len_count", 32'(n_err_len), 32'(exp_err_len));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_valid"}, 32'(m_axis_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_axis_data), 32'd0);
    check({tag, "_m_flags"}, {28'd0, m_axis_last, m_axis_sop, m_axis_is_parity, m_axis_is_asm}, 32'd0);
    check({tag, "_s_ready"}, 32'(s_axis_ready), 32'd0);
    check({tag, "_errs"}, {30'd0, err_sop, err_len}, 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // Downstream ready: always high, or random when backpressure is enabled.
  initial begin
    m_axis_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge the values the next rising edge will see.
  initial begin
    out_t e;
    bit   stall_prev, fc_pending;
    logic [7:0] p_data;
    logic [3:0] p_flags;
    stall_prev = 0;
    fc_pending = 0;
    p_data = '0;
    p_flags = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall_prev = 0;
        fc_pending = 0;
        exp_fc = '0;
      end else begin
        if (err_sop) n_err_sop++;
        if (err_len) n_err_len++;
        if (fc_pending) begin
          check("frame_count", 32'(frame_count), 32'(exp_fc));
          fc_pending = 0;
        end
        if (stall_prev) begin
          check("stall_valid", 32'(m_axis_valid), 32'd1);
          check("stall_data", 32'(m_axis_data), 32'(p_data));
          check("stall_flags", 32'({m_axis_sop, m_axis_last, m_axis_is_asm, m_axis_is_parity}), 32'(p_flags));
        end
        if (m_axis_is_asm) check("s_ready_in_asm", 32'(s_axis_ready), 32'd0);
        if (m_axis_valid && m_axis_ready) begin
          check("out_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", 32'(m_axis_data), 32'(e.data));
            check("out_sop", 32'(m_axis_sop), 32'(e.sop));
            check("out_last", 32'(m_axis_last), 32'(e.last));
            check("out_is_parity", 32'(m_axis_is_parity), 32'(e.par));
            check("out_is_asm", 32'(m_axis_is_asm), 32'(e.is_asm));
            if (e.sop && gap_mode && last_cyc >= 0) check("b2b_gap", 32'(cyc - last_cyc), 32'd2);
            if (e.last) begin
              exp_fc = exp_fc + 1'b1;
              fc_pending = 1;
              last_cyc = cyc;
            end
          end
        end
        stall_prev = m_axis_valid && !m_axis_ready;
        p_data  = m_axis_data;
        p_flags = {m_axis_sop, m_axis_last, m_axis_is_asm, m_axis_is_parity};
      end
    end
  end

  initial begin
    in_t stray;
    rst = 1'b1;
    s_axis_valid = 1'b1;
    s_axis_sop = 1'b0;
    s_axis_last = 1'b0;
    s_axis_data = 8'hA5;
    s_axis_is_parity = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    s_axis_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("idle");

    // Single block with a counting pattern and no backpressure.
    add_block(0, BLOCK_LEN - 1, -1, -1, 1, 0);
    run_model();
    send(0);
    drain();

    // Same block under random backpressure and input gaps.
    rand_ready = 1;
    add_block(0, BLOCK_LEN - 1, -1, -1, 1, 0);
    run_model();
    send(20);
    drain();
    rand_ready = 0;

    // Three back-to-back blocks with continuous valid and parity on 400..511.
    gap_mode = 1;
    last_cyc = -1;
    repeat (3) add_block(1, BLOCK_LEN - 1, -1, -1, 400, BLOCK_LEN - 1);
    run_model();
    send(0);
    drain();
    gap_mode = 0;

    // Framing errors: a stray byte in IDLE, a block with an early last and a
    // stray sop, and a block with no last at all.
    stray.data = 8'h55;
    stray.sop = 0;
    stray.last = 0;
    stray.par = 1;
    stim_q.push_back(stray);
    add_block(1, 299, BLOCK_LEN - 1, 50, 10, 20);
    add_block(1, -1, -1, -1, 1, 0);
    run_model();
    send(10);
    drain();

    // Reset in the middle of a frame, after 100 data bytes.
    add_block(1, BLOCK_LEN - 1, -1, -1, 1, 0);
    stim_q = stim_q[0:99];
    run_model();
    send(0);
    check("pre_reset_drain", 32'(exp_q.size()), 32'd0);
    check("pre_reset_in_data", 32'(s_axis_ready), 32'd1);
    rst = 1'b1;
    s_axis_valid = 1'b1;
    s_axis_sop = 1'b0;
    #1;
    check_quiet("midreset");
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
    rst = 1'b0;

    // Five random blocks with backpressure. frame_count runs 1,2,3,0,1.
    rand_ready = 1;
    repeat (5) begin
      int lo;
      lo = $urandom_range(BLOCK_LEN - 1);
      add_block(1, BLOCK_LEN - 1, -1, -1, lo, lo + $urandom_range(100));
    end
    run_model();
    send(15);
    drain();
    check("frame_count_wrap", 32'(frame_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
